// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared codes, stall patterns and FSM encoding for the pipeline controller
// Contents:
//   EXC_CODE_WIDTH, EC_* exception codes (EC_None / EC_Eret are markers, not CP0 causes)
//   Stall bus type, Stop/NoStop bit values, STALL_ID/STALL_EX/STALL_MEM patterns
//   ctrl_state_t (CTRL_IDLE / CTRL_FLUSH), merge_stall() priority helper
package pipeline_ctrl_pkg;

    localparam int EXC_CODE_WIDTH = 5;

    localparam logic [EXC_CODE_WIDTH-1:0] EC_Int        = 5'h00;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_AdEL       = 5'h04;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_Sys        = 5'h08;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_Bp         = 5'h09;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_RI         = 5'h0a;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_Ov         = 5'h0c;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_BusTimeout = 5'h1d;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_Eret       = 5'h1e;
    localparam logic [EXC_CODE_WIDTH-1:0] EC_None       = 5'h1f;

    localparam int STALL_WIDTH = 6;
    typedef logic [STALL_WIDTH-1:0] Stall;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
    localparam Stall STALL_NONE = {STALL_WIDTH{NoStop}};
    localparam Stall STALL_ID   = 6'b000111;
    localparam Stall STALL_EX   = 6'b001111;
    localparam Stall STALL_MEM  = 6'b011111;

    typedef enum logic {
        CTRL_IDLE  = 1'b0,
        CTRL_FLUSH = 1'b1
    } ctrl_state_t;

    // Deeper stage wins: a stalled stage must also freeze everything upstream of it.
    function automatic Stall merge_stall(input logic id_req, input logic ex_req, input logic mem_req);
        Stall s;
        s = STALL_NONE;
        if (mem_req) begin
            s = STALL_MEM;
        end else if (ex_req) begin
            s = STALL_EX;
        end else if (id_req) begin
            s = STALL_ID;
        end
        return s;
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// rtl/bus_timeout_cnt.sv - saturating count of consecutive data-bus wait cycles
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset
//   clr   : synchronous clear (takes priority over inc)
//   inc   : count one more waiting cycle
//   hit   : count has reached LIMIT-1; the next waiting cycle is the LIMIT-th
module bus_timeout_cnt #(
    parameter  int LIMIT = 256,
    localparam int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [W-1:0] MAX = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

    assign hit = (count == MAX);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall merge, exception/ERET flush sequencing and bus-timeout for MiniMIPS32
// Ports:
//   cpu_clk_75M   : clock
//   cpu_rst       : synchronous active-high reset
//   id_stall_req  : load-use hazard in ID
//   ex_stall_req  : multi-cycle op busy in EX
//   mem_stall_req : MEM waiting on the data bus
//   mem_exc_code  : exception committed at MEM (EC_None = none, EC_Eret = return)
//   mem_exc_epc   : EPC of the MEM-stage exception
//   cp0_epc       : ERET target
//   stall         : per-stage stop bits (bit0 PC .. bit5 WB)
//   flush         : one-cycle flush pulse
//   flush_pc      : redirect PC, valid with flush
//   exc_take      : one-cycle pulse for CP0 to latch exc_code_o / exc_epc_o
//   exc_code_o    : exception code taken
//   exc_epc_o     : EPC taken
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int          BUS_TIMEOUT = 256
) (
    input  logic                      cpu_clk_75M,
    input  logic                      cpu_rst,
    input  logic                      id_stall_req,
    input  logic                      ex_stall_req,
    input  logic                      mem_stall_req,
    input  logic [EXC_CODE_WIDTH-1:0] mem_exc_code,
    input  logic [31:0]               mem_exc_epc,
    input  logic [31:0]               cp0_epc,
    output Stall                      stall,
    output logic                      flush,
    output logic [31:0]               flush_pc,
    output logic                      exc_take,
    output logic [EXC_CODE_WIDTH-1:0] exc_code_o,
    output logic [31:0]               exc_epc_o
);

    ctrl_state_t state_q, state_d;

    logic                      real_exc;
    logic                      tmo_hit;
    logic                      tmo_fire;
    logic                      exc_pending;
    logic                      cnt_inc;
    logic                      cnt_clr;

    logic                      flush_d;
    logic [31:0]               flush_pc_d;
    logic                      exc_take_d;
    logic [EXC_CODE_WIDTH-1:0] exc_code_d;
    logic [31:0]               exc_epc_d;

    assign real_exc    = (mem_exc_code != EC_None);
    assign tmo_fire    = mem_stall_req && tmo_hit;
    // Only IDLE can trigger; anything arriving during FLUSH belongs to a squashed instruction.
    assign exc_pending = (state_q == CTRL_IDLE) && (real_exc || tmo_fire);

    assign cnt_inc = (state_q == CTRL_IDLE) && mem_stall_req;
    assign cnt_clr = !mem_stall_req || exc_pending;

    bus_timeout_cnt #(
        .LIMIT (BUS_TIMEOUT)
    ) u_timeout_cnt (
        .clk (cpu_clk_75M),
        .rst (cpu_rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .hit (tmo_hit)
    );

    // Stalls must never hold back a flush, so they are dropped while one is pending or in progress.
    always_comb begin
        stall = STALL_NONE;
        if (!cpu_rst && (state_q == CTRL_IDLE) && !exc_pending) begin
            stall = merge_stall(id_stall_req, ex_stall_req, mem_stall_req);
        end
    end

    always_ff @(posedge cpu_clk_75M) begin
        if (cpu_rst) begin
            state_q    <= CTRL_IDLE;
            flush      <= 1'b0;
            flush_pc   <= 32'h0;
            exc_take   <= 1'b0;
            exc_code_o <= EC_None;
            exc_epc_o  <= 32'h0;
        end else begin
            state_q    <= state_d;
            flush      <= flush_d;
            flush_pc   <= flush_pc_d;
            exc_take   <= exc_take_d;
            exc_code_o <= exc_code_d;
            exc_epc_o  <= exc_epc_d;
        end
    end

    // exc_code_o / exc_epc_o keep the last taken exception; flush_pc keeps its last redirect.
    always_comb begin
        state_d    = state_q;
        flush_d    = 1'b0;
        exc_take_d = 1'b0;
        flush_pc_d = flush_pc;
        exc_code_d = exc_code_o;
        exc_epc_d  = exc_epc_o;
        unique case (state_q)
            CTRL_IDLE: begin
                if (exc_pending) begin
                    state_d = CTRL_FLUSH;
                    flush_d = 1'b1;
                    if (real_exc && (mem_exc_code == EC_Eret)) begin
                        flush_pc_d = cp0_epc;
                    end else begin
                        flush_pc_d = EXC_VECTOR;
                        exc_take_d = 1'b1;
                        // A real code outranks a timeout seen in the same cycle.
                        exc_code_d = real_exc ? mem_exc_code : EC_BusTimeout;
                        exc_epc_d  = mem_exc_epc;
                    end
                end
            end
            CTRL_FLUSH: begin
                state_d = CTRL_IDLE;
            end
            default: begin
                state_d = CTRL_IDLE;
            end
        endcase
    end

endmodule
